// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
// Write-side initiator for the MIPS register file. Writeback requests are
// accepted over a valid/ready handshake and buffered in an in-order FIFO.
// The FIFO drains one entry per cycle onto the register file's single write
// port. A combinational probe lets the read side see writes that are still
// queued.
//
// Optional feature: define REGFILE_WB_FORWARD_EN to build the forwarding mux
// that drives ProbeData with the youngest matching queued value. Without it,
// ProbeData is tied to zero and only ProbePending is produced.

module regfile_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [4:0]            InRegister,
    input  logic [31:0]           InData,
    input  logic                  Stall,
    output logic [4:0]            WriteRegister,
    output logic [31:0]           WriteData,
    output logic                  RegWrite,
    input  logic [4:0]            ProbeRegister,
    output logic                  ProbePending,
    output logic [31:0]           ProbeData,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Empty
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [4:0]            reg_q  [DEPTH];
    logic [4:0]            reg_d  [DEPTH];
    logic [31:0]           data_q [DEPTH];
    logic [31:0]           data_d [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic push;
    logic pop;

    // Handshake and write-port outputs; the head is shown only when the queue holds something
    always_comb begin
        Empty         = (count_q == '0);
        InReady       = (count_q != FULL_COUNT);
        RegWrite      = !Empty && !Stall;
        WriteRegister = Empty ? 5'd0  : reg_q[rd_ptr_q];
        WriteData     = Empty ? 32'd0 : data_q[rd_ptr_q];
        Count         = count_q;
        // Writes to $zero finish the handshake but are dropped here
        push          = InValid && InReady && (InRegister != 5'd0);
        pop           = RegWrite;
    end

    // Next-state for the FIFO storage, pointers and occupancy
    always_comb begin
        reg_d    = reg_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            reg_d[wr_ptr_q]  = InRegister;
            data_d[wr_ptr_q] = InData;
            wr_ptr_d         = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Probe scans entries oldest to youngest so the last match is the youngest
    always_comb begin
        logic [DEPTH_LOG2-1:0] idx;
        logic                  pending;
        logic [31:0]           fwd;
        idx     = '0;
        pending = 1'b0;
        fwd     = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + DEPTH_LOG2'(k);
            if ((CW'(k) < count_q) && (ProbeRegister != 5'd0) &&
                (reg_q[idx] == ProbeRegister)) begin
                pending = 1'b1;
`ifdef REGFILE_WB_FORWARD_EN
                fwd = data_q[idx];
`endif
            end
        end
        ProbePending = pending;
`ifdef REGFILE_WB_FORWARD_EN
        ProbeData = fwd;
`else
        ProbeData = 32'd0;
`endif
    end

    // State registers; reset empties the queue immediately, discarding pending writes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= 5'd0;
                data_q[i] <= 32'd0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            reg_q    <= reg_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Testbench for regfile_writeback_queue: directed scenarios followed by
// randomized traffic, checked by a scoreboard of expected register writes.

module tb_regfile_writeback_queue;

    localparam int DEPTH      = 4;
    localparam int DEPTH_LOG2 = 2;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    logic                Clk;
    logic                Reset;
    logic                InValid;
    logic                InReady;
    logic [4:0]          InRegister;
    logic [31:0]         InData;
    logic                Stall;
    logic [4:0]          WriteRegister;
    logic [31:0]         WriteData;
    logic                RegWrite;
    logic [4:0]          ProbeRegister;
    logic                ProbePending;
    logic [31:0]         ProbeData;
    logic [DEPTH_LOG2:0] Count;
    logic                Empty;

    entry_t expQ[$];
    int     modelCount;
    int     checkCount;
    int     passCount;

    regfile_writeback_queue #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .InValid       (InValid),
        .InReady       (InReady),
        .InRegister    (InRegister),
        .InData        (InData),
        .Stall         (Stall),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ProbeRegister (ProbeRegister),
        .ProbePending  (ProbePending),
        .ProbeData     (ProbeData),
        .Count         (Count),
        .Empty         (Empty)
    );

    // Free-running clock, 10 time units per cycle
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge and wait for the next one
    task automatic applyStimulus(input logic valid, input logic [4:0] r,
                                 input logic [31:0] d, input logic stall,
                                 input logic [4:0] probe);
        InValid       = valid;
        InRegister    = r;
        InData        = d;
        Stall         = stall;
        ProbeRegister = probe;
        @(posedge Clk);
        #1;
    endtask

    // Assert reset between edges and check that the outputs clear at once
    task automatic applyReset();
        InValid = 1'b0;
        Stall   = 1'b0;
        Reset   = 1'b1;
        expQ.delete();
        modelCount = 0;
        #1;
        checkOutput("reset RegWrite", RegWrite, 0);
        checkOutput("reset Count", Count, 0);
        checkOutput("reset Empty", Empty, 1);
        checkOutput("reset InReady", InReady, 1);
        checkOutput("reset WriteRegister", WriteRegister, 0);
        checkOutput("reset WriteData", WriteData, 0);
        checkOutput("reset ProbePending", ProbePending, 0);
        checkOutput("reset ProbeData", ProbeData, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    // Reference model: on each edge, accept a request when the modelled queue has room,
    // drop $zero writes, and retire the head when not stalled
    always @(posedge Clk) begin
        if (Reset) begin
            modelCount = 0;
        end else begin
            automatic bit accept = InValid && (modelCount < DEPTH);
            automatic bit retire = (modelCount > 0) && !Stall;
            if (accept && InRegister != 5'd0) begin
                automatic entry_t e;
                e.r = InRegister;
                e.d = InData;
                expQ.push_back(e);
                modelCount++;
            end
            if (retire) modelCount--;
        end
    end

    // Monitor: mid-cycle, compare status, probe and write port against the scoreboard,
    // and consume the expected write whenever the DUT should present one
    always @(negedge Clk) begin
        automatic bit          expWrite = (modelCount > 0) && !Stall && !Reset;
        automatic bit          expPend  = 1'b0;
        automatic logic [31:0] expFwd   = 32'd0;
        foreach (expQ[i]) begin
            if (ProbeRegister != 5'd0 && expQ[i].r == ProbeRegister) begin
                expPend = 1'b1;
                expFwd  = expQ[i].d;
            end
        end
`ifndef REGFILE_WB_FORWARD_EN
        expFwd = 32'd0;
`endif
        checkOutput("Count", Count, modelCount);
        checkOutput("Empty", Empty, modelCount == 0);
        checkOutput("InReady", InReady, modelCount < DEPTH);
        checkOutput("RegWrite", RegWrite, expWrite);
        checkOutput("ProbePending", ProbePending, expPend);
        checkOutput("ProbeData", ProbeData, expFwd);
        if (expQ.size() > 0) begin
            checkOutput("WriteRegister", WriteRegister, expQ[0].r);
            checkOutput("WriteData", WriteData, expQ[0].d);
        end else begin
            checkOutput("WriteRegister idle", WriteRegister, 0);
            checkOutput("WriteData idle", WriteData, 0);
        end
        if (expWrite && expQ.size() > 0) begin
            void'(expQ.pop_front());
        end
    end

    // Directed scenarios, then randomized traffic, then a final drain
    initial begin
        checkCount    = 0;
        passCount     = 0;
        modelCount    = 0;
        InValid       = 1'b0;
        InRegister    = 5'd0;
        InData        = 32'd0;
        Stall         = 1'b0;
        ProbeRegister = 5'd0;
        Reset         = 1'b1;
        #1;
        checkOutput("power-on Count", Count, 0);
        checkOutput("power-on Empty", Empty, 1);
        checkOutput("power-on RegWrite", RegWrite, 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Single write, one-cycle latency
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd5);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd5);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0);

        // Register 0 is dropped
        applyStimulus(1, 5'd0, 32'h12345678, 0, 5'd0);
        repeat (2) applyStimulus(0, 5'd0, 32'h0, 0, 5'd0);

        // Fill while stalled, hold a fifth request, then release
        applyStimulus(1, 5'd1, 32'h11, 1, 5'd3);
        applyStimulus(1, 5'd2, 32'h22, 1, 5'd3);
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd3);
        applyStimulus(1, 5'd4, 32'h44, 1, 5'd3);
        applyStimulus(1, 5'd6, 32'h66, 1, 5'd6);
        applyStimulus(1, 5'd6, 32'h66, 1, 5'd6);
        applyStimulus(1, 5'd6, 32'h66, 0, 5'd6);
        applyStimulus(1, 5'd6, 32'h66, 0, 5'd6);
        repeat (6) applyStimulus(0, 5'd0, 32'h0, 0, 5'd6);

        // Two pending writes to r7; probe r7 then r8
        applyStimulus(1, 5'd7, 32'hA, 1, 5'd7);
        applyStimulus(1, 5'd7, 32'hB, 1, 5'd7);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd7);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd8);
        repeat (3) applyStimulus(0, 5'd0, 32'h0, 0, 5'd7);

        // Two queued, then push every cycle while draining to wrap pointers
        applyStimulus(1, 5'd11, 32'h1111, 1, 5'd9);
        applyStimulus(1, 5'd12, 32'h2222, 1, 5'd9);
        applyStimulus(1, 5'd9, 32'h99, 0, 5'd9);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            applyStimulus(1, 5'(13 + i), 32'h1000 + i, 0, 5'(13 + i));
        end
        repeat (4) applyStimulus(0, 5'd0, 32'h0, 0, 5'd0);

        // Reset mid-drain discards the queue
        applyStimulus(1, 5'd20, 32'h20, 1, 5'd20);
        applyStimulus(1, 5'd21, 32'h21, 1, 5'd21);
        applyStimulus(1, 5'd22, 32'h22, 1, 5'd22);
        applyReset();
        applyStimulus(1, 5'd10, 32'hCAFE, 0, 5'd20);
        repeat (2) applyStimulus(0, 5'd0, 32'h0, 0, 5'd10);

        // Randomized traffic with a small register range to provoke probe hits and r0 drops
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          5'($urandom_range(0, 7)),
                          $urandom,
                          $urandom_range(0, 3) == 0,
                          5'($urandom_range(0, 7)));
        end

        repeat (DEPTH + 2) applyStimulus(0, 5'd0, 32'h0, 0, 5'd0);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
